// File: rtl/burst_pulse_gen_if.sv
// Trigger/config and status bundle for burst_pulse_gen.
// master drives trigger and configuration; slave is the generator itself.
interface burst_pulse_gen_if #(
  parameter int unsigned CNT_W = 6,
  parameter int unsigned IDX_W = 4
);
  logic             ena;
  logic [CNT_W-1:0] hi_len;
  logic [CNT_W-1:0] lo_len;
  logic [IDX_W-1:0] n_pulses;
  logic             F;
  logic             flag;
  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] pulse_idx;

  modport master (
    output ena, hi_len, lo_len, n_pulses,
    input  F, flag, busy, cnt, pulse_idx
  );

  modport slave (
    input  ena, hi_len, lo_len, n_pulses,
    output F, flag, busy, cnt, pulse_idx
  );
endinterface

// File: rtl/burst_pulse_gen.sv
// Edge-triggered burst generator: n pulses of hi cycles high / lo cycles low, then a done strobe.
// Optional macro BURST_RETRIGGER_EN: a new trigger edge during a burst restarts it.
module burst_pulse_gen #(
  parameter int unsigned CNT_W = 6,
  parameter int unsigned IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  burst_pulse_gen_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ena_d;
  logic [CNT_W-1:0] hi_q, lo_q;
  logic [IDX_W-1:0] n_q;
  logic             f_q, flag_q, busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;

  logic             f_d, flag_d, busy_d, load;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] idx_d;

  logic start, accept, go, empty;
  logic hi_done, lo_done, last_pulse;

  assign start = bus.ena & ~ena_d;

  // Whether a trigger edge is honoured depends on the retrigger build option
`ifdef BURST_RETRIGGER_EN
  assign accept = start;
`else
  assign accept = start & (state_q == IDLE);
`endif

  assign go         = accept & (bus.n_pulses != '0);
  assign empty      = accept & (bus.n_pulses == '0);
  assign hi_done    = (cnt_q == hi_q - CNT_W'(1));
  assign lo_done    = (cnt_q == lo_q - CNT_W'(1));
  assign last_pulse = (idx_q == n_q - IDX_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (go) begin
      state_d = HIGH;
    end else if (empty) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        HIGH: if (hi_done) state_d = LOW;
        LOW:  if (lo_done) state_d = last_pulse ? IDLE : HIGH;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath next values
  always_comb begin
    f_d    = (state_d == HIGH);
    busy_d = (state_d != IDLE);
    flag_d = 1'b0;
    load   = 1'b0;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    if (accept) begin
      // An empty burst completes immediately
      load   = go;
      flag_d = empty;
      cnt_d  = '0;
      idx_d  = '0;
    end else begin
      case (state_q)
        HIGH: cnt_d = hi_done ? '0 : cnt_q + CNT_W'(1);
        LOW: begin
          if (lo_done) begin
            cnt_d = '0;
            if (last_pulse) begin
              idx_d  = '0;
              flag_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d = '0;
          idx_d = '0;
        end
      endcase
    end
  end

  // Registered outputs, trigger history and latched configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_d  <= 1'b0;
      f_q    <= 1'b0;
      flag_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      n_q    <= '0;
    end else begin
      ena_d  <= bus.ena;
      f_q    <= f_d;
      flag_q <= flag_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      if (load) begin
        hi_q <= (bus.hi_len == '0) ? CNT_W'(1) : bus.hi_len;
        lo_q <= (bus.lo_len == '0) ? CNT_W'(1) : bus.lo_len;
        n_q  <= bus.n_pulses;
      end
    end
  end

  assign bus.F         = f_q;
  assign bus.flag      = flag_q;
  assign bus.busy      = busy_q;
  assign bus.cnt       = cnt_q;
  assign bus.pulse_idx = idx_q;

endmodule
